load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the single-cycle core datapath and a handshaked data-memory bus. Consumes the datapath's ALU address, store data and Instr[14:12]. Drives a word-aligned request with byte enables, then returns sign/zero-extended load data. Holds the core with `Stall` until the access completes, so the PC register and register-file write are gated for multi-cycle memory.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ+RESP before aborting with `BusFault`; range 1..65535.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-low; one clock; clears FSM, counters and registered outputs.
- `MemRead` in 1: current instruction is a load.
- `MemWrite` in 1: current instruction is a store; wins if both are asserted.
- `Funct3` in 3: access size/sign, Instr[14:12] (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `Addr` in 32: byte address (ALUResult).
- `WriteData` in 32: store data, taken from the rs2 read port.
- `ReadData` out 32: formatted load data; valid only in DONE, 0 otherwise.
- `Stall` out 1: core must not advance PC or write registers.
- `MisalignedFault` out 1: one-cycle pulse for a misaligned or illegal-Funct3 access.
- `BusFault` out 1: one-cycle pulse (DONE) when a timeout occurs.
- `mem_valid` out 1: request valid.
- `mem_ready` in 1: request accepted when `mem_valid && mem_ready`.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{Addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1: read response valid; ignored outside RESP.
- `mem_rdata` in 32: read response word.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, no access: `Stall=0`.
- IDLE with an aligned access:
  - latch `mem_addr`, `mem_be`, `mem_wdata`, `mem_we`, Funct3 and Addr[1:0];
  - `Stall=1` combinationally;
  - next state REQ.
- IDLE with a misaligned access (H with Addr[0]=1; W with Addr[1:0]≠0) or illegal Funct3 (011, 110, 111; 011 and 1xx for stores):
  - no bus request;
  - `MisalignedFault=1` for that cycle, `Stall=0`, `ReadData=0`.
- REQ:
  - `mem_valid=1`; request fields stay stable until accepted.
  - On accept: load goes to RESP; store goes to DONE.
- RESP: on `mem_rvalid`, capture `mem_rdata`, go to DONE.
- DONE:
  - `Stall=0`; `ReadData` is valid;
  - always returns to IDLE, so the same instruction is never re-issued.
- Timeout:
  - the counter resets on entering REQ and increments each cycle in REQ/RESP;
  - reaching `TIMEOUT_CYCLES` forces DONE with `BusFault=1` and `ReadData=0`; `mem_valid` drops.
- Byte enables:
  - SB: `4'b0001<<Addr[1:0]`;
  - SH: `4'b0011<<{Addr[1],1'b0}`;
  - SW: `4'b1111`.
- Store data: SB replicates `WriteData[7:0]` ×4; SH replicates `WriteData[15:0]` ×2; SW passes the word through.
- Load data:
  - select the lane as `rdata >> (8*Addr[1:0])`;
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

## Timing
- Reset values (asynchronous, active-low): state IDLE, `mem_valid=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`, `ReadData=0`, `BusFault=0`, timeout counter 0.
- Minimum latency with a zero-wait bus (ready with valid, rvalid the next cycle):
  - load: 4 cycles, IDLE→REQ→RESP→DONE;
  - store: 3 cycles.
- Each cycle `mem_ready` stays low adds one cycle in REQ; each cycle `mem_rvalid` stays low adds one cycle in RESP.
- `Stall` is combinational from IDLE inputs and FSM state; all bus outputs are registered.
- Reset asserted mid-access: immediate IDLE, `mem_valid` deasserts asynchronously, and any pending response is dropped.
- `mem_rvalid` outside RESP is ignored.
- `mem_ready` and `mem_rvalid` both high in the REQ cycle: only the accept is taken; rvalid is required in RESP.

## Structure
- Package `lsu_pkg` holds:
  - the state encoding: IDLE=2'd0, REQ=2'd1, RESP=2'd2, DONE=2'd3;
  - Funct3 constants F3_B/H/W/BU/HU;
  - the byte-enable constants.
- Sub-module `lsu_align` (combinational) holds the byte-enable, store-replication and load-extraction logic, so it can be unit-tested separately.
- The FSM, timeout counter and request registers sit in `load_store_unit`.

## Test plan
- SW: Addr=0x1004, WriteData=0xDEADBEEF, zero-wait bus → `mem_addr=0x1004`, `mem_be=1111`, `mem_wdata=0xDEADBEEF`, `Stall` high for 2 cycles, DONE in cycle 2.
- LB: Addr=0x2003, rdata=0x80FF_0000 → `ReadData=0xFFFFFF80`. LBU with the same stimulus → `0x00000080`.
- SH: Addr=0x2002, WriteData=0x1234ABCD → `mem_be=1100`, `mem_wdata=0xABCDABCD`.
- LW with `mem_ready` low 3 cycles and `mem_rvalid` low 2 cycles → DONE on cycle 8, `ReadData=mem_rdata`, `mem_addr` stable throughout REQ.
- LH at Addr=0x3001 → `MisalignedFault` pulses 1 cycle, `mem_valid` never rises, `Stall=0`.
- `TIMEOUT_CYCLES=4` with `mem_ready` stuck low → `BusFault` pulse in DONE after 4 REQ cycles. Separately, assert `reset` low mid-REQ → `mem_valid=0` the same cycle and state IDLE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding,
// Funct3 access codes, byte-enable patterns and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Unsigned loads have no store counterpart, so 1xx is illegal for stores.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic is_store);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: store byte enables and replication, load lane extraction and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  // Store side: enables and lane replication by access size
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'd0;
    case (i_st_funct3[1:0])
      2'b00: begin
        o_be    = BE_B << i_st_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = BE_H << {i_st_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        o_be    = BE_W;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'd0;
      end
    endcase
  end

  assign w_lane = i_rdata >> {i_ld_addr_lo, 3'b000};

  // Load side: sign or zero extension of the selected lane
  always_comb begin
    o_rdata = 32'd0;
    case (i_ld_funct3)
      F3_B:    o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_W:    o_rdata = i_rdata;
      F3_BU:   o_rdata = {24'd0, w_lane[7:0]};
      F3_HU:   o_rdata = {16'd0, w_lane[15:0]};
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: stalls the core while a word-aligned request
// is issued on the memory bus and formats the returned load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          Funct3,
  input  logic [31:0]         Addr,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic                Stall,
  output logic                MisalignedFault,
  output logic                BusFault,
  load_store_unit_if.master   mem
);

  localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [15:0] r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic        r_mem_valid;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_read_data;
  logic        r_bus_fault;

  logic        w_access;
  logic        w_legal;
  logic        w_start;
  logic        w_accept;
  logic        w_expired;
  logic        w_capture;
  logic        w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  assign w_access  = MemRead | MemWrite;
  assign w_legal   = access_legal(Funct3, Addr[1:0], MemWrite);
  assign w_start   = (r_state == IDLE) & w_access & w_legal;
  assign w_accept  = r_mem_valid & mem.mem_ready;
  assign w_expired = (r_cnt >= C_CNT_LAST);

  lsu_align u_align (
    .i_st_funct3  (Funct3),
    .i_st_addr_lo (Addr[1:0]),
    .i_wdata      (WriteData),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem.mem_rdata),
    .o_rdata      (w_ld_data)
  );

  // Next-state, stall and completion decode
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_fault   = 1'b0;
    Stall     = 1'b0;
    case (r_state)
      IDLE: begin
        Stall = w_start;
        if (w_start) w_next = REQ;
        else         w_next = IDLE;
      end
      REQ: begin
        Stall = 1'b1;
        if (w_accept) begin
          if (r_mem_we) w_next = DONE;
          else          w_next = RESP;
        end else if (w_expired) begin
          w_next  = DONE;
          w_fault = 1'b1;
        end else begin
          w_next = REQ;
        end
      end
      RESP: begin
        Stall = 1'b1;
        if (mem.mem_rvalid) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end else if (w_expired) begin
          w_next  = DONE;
          w_fault = 1'b1;
        end else begin
          w_next = RESP;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign MisalignedFault = (r_state == IDLE) & w_access & ~w_legal;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Request fields, timeout counter and registered results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 16'd0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_read_data <= 32'd0;
      r_bus_fault <= 1'b0;
    end else begin
      r_bus_fault <= w_fault;
      r_read_data <= w_capture ? w_ld_data : 32'd0;
      if (w_start) begin
        r_cnt       <= 16'd0;
        r_funct3    <= Funct3;
        r_addr_lo   <= Addr[1:0];
        r_mem_valid <= 1'b1;
        r_mem_we    <= MemWrite;
        r_mem_addr  <= {Addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= MemWrite ? w_wdata : 32'd0;
      end else begin
        if ((r_state == REQ) || (r_state == RESP)) r_cnt <= r_cnt + 16'd1;
        if ((r_state == REQ) && (w_next != REQ))  r_mem_valid <= 1'b0;
      end
    end
  end

  assign ReadData      = r_read_data;
  assign BusFault      = r_bus_fault;
  assign mem.mem_valid = r_mem_valid;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_be    = r_mem_be;
  assign mem.mem_wdata = r_mem_wdata;

endmodule
